adjust_repeater: RTL and testbench
==================================

# adjust_repeater

Converts the debounced `adjust` level from the button conditioner into single-cycle `step` pulses for the time-setting counters. A press gives one immediate step. Holding the button gives auto-repeat after a hold delay, then a faster repeat rate after a set number of repeats. Sits between the button smoother output and the hour/minute increment logic of the clock.

## Interface
- `HOLD_CYCLES`, 50, cycles from the first step to the first repeat step; must be ≥2
- `REPEAT_CYCLES`, 10, slow repeat period in cycles; must be ≥2
- `FAST_AFTER`, 8, number of slow repeat steps before switching to fast rate; range 1..255
- `FAST_CYCLES`, 4, fast repeat period in cycles; must be ≥2
- `CNT_W`, 16, cycle counter width; must hold max(HOLD_CYCLES, REPEAT_CYCLES, FAST_CYCLES)−1
- `clk`  input  1  system clock; all logic on posedge
- `clear_n`  input  1  reset, asynchronous, active-low
- `adjust`  input  1  debounced button level, synchronous to `clk`
- `enable`  input  1  1 = time-setting mode active; 0 = suppress steps
- `step`  output  1  registered one-cycle increment pulse
- `repeating`  output  1  registered; 1 while in REPEAT state
- `fast`  output  1  registered; 1 while the fast repeat rate is in effect

## Operation
- State machine with four states: IDLE, WAIT, REPEAT, LOCKOUT. Also a cycle counter `cnt` (CNT_W bits) and a repeat counter `rep` (8 bits, saturates at FAST_AFTER).
- `step` defaults to 0 every cycle. It is 1 only in the cycle after an edge that fires a step.
- Priority at each edge, highest first: `enable`=0, then `adjust`=0, then counter events.
- Any state with `enable`=0:
  - Go to LOCKOUT if `adjust`=1, else go to IDLE.
  - cnt←0, rep←0, no step.
- IDLE:
  - If `adjust`=1: step, go to WAIT, cnt←0.
  - Otherwise stay in IDLE.
- WAIT:
  - If `adjust`=0: go to IDLE, cnt←0, no step.
  - Else if cnt==HOLD_CYCLES−1: step, go to REPEAT, cnt←0, rep←0.
  - Else cnt←cnt+1.
- REPEAT:
  - The period P is REPEAT_CYCLES if rep<FAST_AFTER, else FAST_CYCLES.
  - If `adjust`=0: go to IDLE, cnt←0, rep←0, no step.
  - Else if cnt==P−1: step, cnt←0, rep←rep+1 (saturating at FAST_AFTER).
  - Else cnt←cnt+1.
- LOCKOUT:
  - Go to IDLE only when `adjust`=0 and `enable`=1.
  - A button still held through a mode change never generates steps.
- `repeating` = (state==REPEAT). `fast` = (state==REPEAT && rep==FAST_AFTER). Both are registered alongside the state.
- If release is sampled on the same edge a step would fire, release wins: no step.

## Timing
- Reset (`clear_n`=0): immediately and asynchronously, state=IDLE, cnt=0, rep=0, `step`=0, `repeating`=0, `fast`=0. Reset asserted mid-hold discards all progress.
- After reset release, the first posedge sampling `adjust`=1 with `enable`=1 produces a step.
- Press sampled at edge k:
  - First step: high between edges k and k+1.
  - Second step: at edge k+HOLD_CYCLES.
  - Slow repeats: every REPEAT_CYCLES edges after that, FAST_AFTER times.
  - Then every FAST_CYCLES edges.
- `step` never stays high for two consecutive cycles, because every period is ≥2.
- Latency from the `adjust` rising edge to `step` is 1 cycle (registered).
- `rep` saturation: no wrap. `fast` stays 1 until release.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=5, REPEAT_CYCLES=3, FAST_AFTER=2, FAST_CYCLES=2, `enable`=1 unless stated.

- **Short press:** `adjust`=1 sampled at edges 10–12, then 0 → exactly one `step`, after edge 10; `repeating` stays 0.
- **Full hold:** `adjust`=1 sampled at edges 10–29, 0 at edge 30.
  - `step` after edges 10, 15, 18, 21, 23, 25, 27, 29.
  - `repeating`=1 from edge 15 to edge 30.
  - `fast`=1 from edge 21 to edge 30.
- **Release on fire edge:** `adjust`=1 at edges 10–14, 0 at edge 15 → single step after edge 10, none at 15; state IDLE. Re-press at edge 17 → step after edge 17.
- **Enable drop while held:**
  - `enable`=0 at edge 16 during a hold started at edge 10 → no further steps, state LOCKOUT.
  - `enable`=1 again at edge 20 with `adjust` still 1 → no step.
  - `adjust`=0 at edge 24, then 1 at edge 26 → step after edge 26.
- **Async reset mid-repeat:** `clear_n` pulled low between edges 19 and 20 → `step`, `repeating` and `fast` drop to 0 without waiting for a clock edge. Release before edge 22 with `adjust` held 1 → step after edge 22, next step after edge 27.

Source files
------------

// File: rtl/adjust_repeater.sv
// Turns a held time-setting button into step pulses: one on press, then
// auto-repeat after a hold delay, switching to a faster rate after FAST_AFTER repeats.
module adjust_repeater #(
  parameter int HOLD_CYCLES   = 50,
  parameter int REPEAT_CYCLES = 10,
  parameter int FAST_AFTER    = 8,
  parameter int FAST_CYCLES   = 4,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic clear_n,
  input  logic adjust,
  input  logic enable,
  output logic step,
  output logic repeating,
  output logic fast
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_REPEAT  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CYCLES - 1);
  localparam logic [7:0]       FAST_N    = 8'(FAST_AFTER);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [7:0]       rep, rep_next;
  logic             step_next;
  logic [CNT_W-1:0] period_last;

  assign period_last = (rep < FAST_N) ? SLOW_LAST : FAST_LAST;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rep_next   = rep;
    step_next  = 1'b0;
    if (!enable) begin
      // A button still held across a mode change is locked out until released.
      state_next = adjust ? S_LOCKOUT : S_IDLE;
      cnt_next   = '0;
      rep_next   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (adjust) begin
            step_next  = 1'b1;
            state_next = S_WAIT;
            cnt_next   = '0;
          end
        end
        S_WAIT: begin
          if (!adjust) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end else if (cnt == HOLD_LAST) begin
            step_next  = 1'b1;
            state_next = S_REPEAT;
            cnt_next   = '0;
            rep_next   = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          if (!adjust) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            rep_next   = '0;
          end else if (cnt == period_last) begin
            step_next = 1'b1;
            cnt_next  = '0;
            if (rep < FAST_N) rep_next = rep + 8'd1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        S_LOCKOUT: begin
          if (!adjust) state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
          cnt_next   = '0;
          rep_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rep       <= '0;
      step      <= 1'b0;
      repeating <= 1'b0;
      fast      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rep       <= rep_next;
      step      <= step_next;
      repeating <= (state_next == S_REPEAT);
      fast      <= (state_next == S_REPEAT) && (rep_next == FAST_N);
    end
  end

endmodule

// File: tb/tb_adjust_repeater.sv
// Scoreboard bench for adjust_repeater: expected step edges are queued by the
// stimulus and matched by a negedge monitor that also checks repeating/fast windows.
module tb_adjust_repeater;

  logic clk = 1'b0;
  logic clear_n = 1'b0;
  logic adjust = 1'b0;
  logic enable = 1'b1;
  logic step, repeating, fast;

  adjust_repeater #(
    .HOLD_CYCLES(5), .REPEAT_CYCLES(3), .FAST_AFTER(2), .FAST_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk(clk), .clear_n(clear_n), .adjust(adjust), .enable(enable),
    .step(step), .repeating(repeating), .fast(fast)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int global_edges = 0;
  int base = 0;
  int rel;
  bit check_en = 1'b0;
  int exp_q[$];
  string scen;
  int rep_a0, rep_a1, rep_b0, rep_b1, fast_0, fast_1;

  always @(posedge clk) global_edges <= global_edges + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s/%s: got %0d expected %0d", scen, name, act, exp);
    end else begin
      $display("ok   %s/%s: %0d", scen, name, act);
    end
  endtask

  // Monitor: sampled mid-cycle, rel is the last edge the DUT has acted on.
  always @(negedge clk) begin
    if (check_en) begin
      rel = global_edges - base;
      if (step) begin
        if (exp_q.size() == 0) chk($sformatf("extra_step@%0d", rel), 1, 0);
        else chk("step_edge", rel, exp_q.pop_front());
      end
      if (repeating !== (((rel >= rep_a0) && (rel < rep_a1)) || ((rel >= rep_b0) && (rel < rep_b1)))) begin
        errors++;
        checks++;
        $display("FAIL %s/repeating@%0d: got %0b", scen, rel, repeating);
      end else checks++;
      if (fast !== ((rel >= fast_0) && (rel < fast_1))) begin
        errors++;
        checks++;
        $display("FAIL %s/fast@%0d: got %0b", scen, rel, fast);
      end else checks++;
    end
  end

  // Runs edges 1..n. adjust is high on edges [a0,a1] and [b0,b1], enable low on
  // [e0,e1], clear_n low on [r0,r1] (asserted mid-cycle before edge r0).
  task automatic run(input int n, input int a0, input int a1, input int b0, input int b1,
                     input int e0, input int e1, input int r0, input int r1);
    check_en = 1'b0;
    adjust = 1'b0;
    enable = 1'b1;
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_step", int'(step), 0);
    chk("reset_repeating", int'(repeating), 0);
    chk("reset_fast", int'(fast), 0);
    clear_n = 1'b1;
    @(negedge clk);
    base = global_edges;
    check_en = 1'b1;
    for (int i = 1; i <= n; i++) begin
      adjust = ((i >= a0) && (i <= a1)) || ((i >= b0) && (i <= b1));
      enable = !((i >= e0) && (i <= e1));
      if (i == r1 + 1) clear_n = 1'b1;
      if (i == r0) begin
        #2 clear_n = 1'b0;
        #1;
        chk("async_step", int'(step), 0);
        chk("async_repeating", int'(repeating), 0);
        chk("async_fast", int'(fast), 0);
      end
      @(negedge clk);
    end
    adjust = 1'b0;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_en = 1'b0;
    chk("missing_steps", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    scen = "short";
    exp_q = '{10};
    rep_a0 = 0; rep_a1 = 0; rep_b0 = 0; rep_b1 = 0; fast_0 = 0; fast_1 = 0;
    run(16, 10, 12, 0, -1, 0, -1, 0, -1);

    scen = "full_hold";
    exp_q = '{10, 15, 18, 21, 23, 25, 27, 29};
    rep_a0 = 15; rep_a1 = 30; rep_b0 = 0; rep_b1 = 0; fast_0 = 21; fast_1 = 30;
    run(34, 10, 29, 0, -1, 0, -1, 0, -1);

    scen = "release_on_fire";
    exp_q = '{10, 17};
    rep_a0 = 0; rep_a1 = 0; rep_b0 = 0; rep_b1 = 0; fast_0 = 0; fast_1 = 0;
    run(24, 10, 14, 17, 19, 0, -1, 0, -1);

    scen = "enable_drop";
    exp_q = '{10, 15, 26};
    rep_a0 = 15; rep_a1 = 16; rep_b0 = 0; rep_b1 = 0; fast_0 = 0; fast_1 = 0;
    run(32, 10, 23, 26, 28, 16, 19, 0, -1);

    scen = "async_reset";
    exp_q = '{10, 15, 18, 22, 27};
    rep_a0 = 15; rep_a1 = 20; rep_b0 = 27; rep_b1 = 28; fast_0 = 0; fast_1 = 0;
    run(30, 10, 27, 0, -1, 0, -1, 20, 21);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
